// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and the future transmitter:
//   - uart_state_t : frame state machine encoding
//   - DEFAULT_OVERSAMPLE / DEFAULT_DATA_BITS : default frame geometry
//   - clog2()      : constant-evaluable ceiling log2 for counter widths
// No ports.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    // Ceiling log2; returns at least 1 so a counter always has a bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sync_bit.sv
// -----------------------------------------------------------------------------
// uart_sync_bit
// SYNC_STAGES-deep flip-flop chain bringing an asynchronous level into the clk
// domain. The chain resets to RESET_VALUE so an idle line reads as idle from
// the first cycle after reset.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   d     in  asynchronous input
//   q     out synchronised output (last stage)
// -----------------------------------------------------------------------------
module uart_sync_bit #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
// 8N1-style UART receiver driven by an OVERSAMPLE-per-bit sample_tick. The rx
// line is synchronised, a falling edge starts a frame, the start bit is
// re-checked at its middle, and every following bit is sampled mid-bit.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit; without it parity_err is tied low.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous, active-high reset
//   sample_tick in  one-clk pulse, OVERSAMPLE per bit period
//   rx          in  asynchronous serial line, idle high
//   rx_data     out last correctly framed word (holds until next good frame)
//   rx_valid    out one-clk pulse: rx_data updated
//   frame_err   out one-clk pulse: stop bit sampled low
//   parity_err  out one-clk pulse: parity mismatch
//   busy        out high whenever a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TICK_W = clog2(OVERSAMPLE);
    localparam int BIT_W  = clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev;
    uart_state_t          state, state_next;
    logic [TICK_W-1:0]    tick_cnt, tick_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 stop_sample;
    logic                 valid_set;
    logic                 frame_set;

    uart_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad, parity_bad_next;
`endif

    // Next-state and counter/shift logic; counters only move on sample_tick.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad;
`endif
        case (state)
            IDLE: begin
                // Edge, not level: a held-low break cannot restart a frame.
                if (rx_prev && !rx_s) begin
                    state_next = START;
                    tick_next  = '0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (tick_cnt == TICK_HALF) begin
                        tick_next = '0;
                        bit_next  = '0;
                        state_next = rx_s ? IDLE : DATA;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        shift_next = {rx_s, shift[DATA_BITS-1:1]};
                        tick_next  = '0;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bit_next = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        // Even parity: line bit must equal XOR of the data.
                        parity_bad_next = (rx_s != ^shift);
                        tick_next  = '0;
                        state_next = STOP;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (sample_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        state_next = IDLE;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        stop_sample = (state == STOP) && sample_tick && (tick_cnt == TICK_LAST);
        valid_set   = stop_sample && rx_s;
        frame_set   = stop_sample && !rx_s;
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_prev   <= 1'b1;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_prev   <= rx_s;
            tick_cnt  <= tick_next;
            bit_cnt   <= bit_next;
            shift     <= shift_next;
            rx_valid  <= valid_set;
            frame_err <= frame_set;
            if (valid_set) begin
                rx_data <= shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_bad <= parity_bad_next;
            parity_err <= stop_sample && parity_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
